// File: rtl/wave_capture_pkg.sv
// Shared definitions for the waveform capture path and the display side.
package wave_pkg;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } cap_state_t;

  localparam int ADDR_W   = 9;
  localparam int OFFSET_W = 8;

endpackage

// File: rtl/wave_capture_if.sv
// Audio sample stream plus the display idle flag, as seen by the capture stage.
interface wave_capture_if #(
  parameter int SAMPLE_W = 16
);
  logic                new_sample_ready;
  logic [SAMPLE_W-1:0] new_sample_in;
  logic                wave_display_idle;

  modport master (output new_sample_ready, output new_sample_in, output wave_display_idle);
  modport slave  (input  new_sample_ready, input  new_sample_in, input  wave_display_idle);
endinterface

// File: rtl/wave_capture_zero_cross.sv
// Positive-going zero-crossing detector on the sample stream.
module zero_cross_detect #(
  parameter int SAMPLE_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  wave_capture_if.slave  smp,
  output logic           pos_cross_o
);

  // Only the sign of the previous sample affects crossing detection.
  logic prev_neg_q;
  logic prev_neg_d;

  always_comb begin
    prev_neg_d = prev_neg_q;
    if (smp.new_sample_ready) begin
      prev_neg_d = smp.new_sample_in[SAMPLE_W-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_neg_q <= 1'b0;
    end else begin
      prev_neg_q <= prev_neg_d;
    end
  end

  assign pos_cross_o = smp.new_sample_ready && prev_neg_q && !smp.new_sample_in[SAMPLE_W-1];

endmodule

// File: rtl/wave_capture.sv
// Capture FSM: arms on a positive crossing, fills the hidden buffer, flips on vblank.
module wave_capture
  import wave_pkg::*;
#(
  parameter int SAMPLE_W    = 16,
  parameter int NUM_SAMPLES = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [ADDR_W-1:0]   write_address,
  output logic                write_enable,
  output logic [7:0]          write_sample,
  output logic                read_index
);

  localparam logic [OFFSET_W-1:0] LAST_OFFSET = OFFSET_W'(NUM_SAMPLES - 1);

  wave_capture_if #(.SAMPLE_W(SAMPLE_W)) smp ();

  assign smp.new_sample_ready  = new_sample_ready;
  assign smp.new_sample_in     = new_sample_in;
  assign smp.wave_display_idle = wave_display_idle;

  logic pos_cross;

  zero_cross_detect #(.SAMPLE_W(SAMPLE_W)) u_zc (
    .clk         (clk),
    .reset       (reset),
    .smp         (smp.slave),
    .pos_cross_o (pos_cross)
  );

  cap_state_t          state_q, state_d;
  logic [OFFSET_W-1:0] count_q, count_d;
  logic                read_index_q, read_index_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic [7:0]          sample_u8;

  // Offset-binary: flip the sign bit of the top byte.
  assign sample_u8 = {~smp.new_sample_in[SAMPLE_W-1], smp.new_sample_in[SAMPLE_W-2 -: 7]};

  logic unused_low_bits;
  assign unused_low_bits = ^smp.new_sample_in[SAMPLE_W-9:0];

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    read_index_d = read_index_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;

    unique case (state_q)
      ARMED: begin
        if (pos_cross) begin
          we_d    = 1'b1;
          addr_d  = {~read_index_q, {OFFSET_W{1'b0}}};
          data_d  = sample_u8;
          count_d = OFFSET_W'(1);
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (smp.new_sample_ready) begin
          we_d    = 1'b1;
          addr_d  = {~read_index_q, count_q};
          data_d  = sample_u8;
          count_d = count_q + 1'b1;
          if (count_q == LAST_OFFSET) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (smp.wave_display_idle) begin
          read_index_d = ~read_index_q;
          state_d      = ARMED;
        end
      end
      default: begin
        state_d = ARMED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARMED;
      count_q      <= '0;
      read_index_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      read_index_q <= read_index_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign write_enable  = we_q;
  assign write_address = addr_q;
  assign write_sample  = data_q;
  assign read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// Self-checking bench for wave_capture: capture-level model plus directed literal checks.
module tb_wave_capture;

  logic       clk;
  logic       reset;
  logic [8:0] write_address;
  logic       write_enable;
  logic [7:0] write_sample;
  logic       read_index;

  wave_capture_if #(.SAMPLE_W(16)) stim ();

  wave_capture #(.SAMPLE_W(16), .NUM_SAMPLES(256)) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (stim.new_sample_ready),
    .new_sample_in     (stim.new_sample_in),
    .wave_display_idle (stim.wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: samples written in the current capture (-1 = waiting for a trigger,
  // 256 = capture complete and waiting for the display to go idle).
  int         m_written;
  int         m_prev;
  logic       m_ri;
  logic       e_we;
  logic [8:0] e_addr;
  logic [7:0] e_data;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_written = -1;
      m_prev    = 0;
      m_ri      = 1'b0;
      e_we      = 1'b0;
      e_addr    = '0;
      e_data    = '0;
    end else begin
      int cur;
      int off;
      cur  = int'($signed(stim.new_sample_in));
      e_we = 1'b0;
      off  = -1;
      if (m_written < 0) begin
        if (stim.new_sample_ready && m_prev < 0 && cur >= 0) begin
          off = 0;
          m_written = 1;
        end
      end else if (m_written < 256) begin
        if (stim.new_sample_ready) begin
          off = m_written;
          m_written++;
        end
      end else if (stim.wave_display_idle) begin
        m_ri = ~m_ri;
        m_written = -1;
      end
      if (off >= 0) begin
        e_we   = 1'b1;
        e_addr = 9'((m_ri ? 0 : 256) + off);
        e_data = 8'((cur + 32768) / 256);
      end
      if (stim.new_sample_ready) m_prev = cur;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("we", int'(write_enable), int'(e_we));
      chk("read_index", int'(read_index), int'(m_ri));
      if (e_we && write_enable) begin
        chk("addr", int'(write_address), int'(e_addr));
        chk("data", int'(write_sample), int'(e_data));
      end
      if (write_enable) wr_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    stim.new_sample_ready = 1'b1;
    stim.new_sample_in    = v;
    tick();
    stim.new_sample_ready = 1'b0;
  endtask

  initial begin
    int base;
    stim.new_sample_ready  = 1'b0;
    stim.new_sample_in     = '0;
    stim.wave_display_idle = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", int'(write_enable), 0);
    chk("rst_addr", int'(write_address), 0);
    chk("rst_data", int'(write_sample), 0);
    chk("rst_ri", int'(read_index), 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Non-negative samples only: no trigger.
    send(16'h0100);
    chk("no_trig_a", int'(write_enable), 0);
    send(16'h0200);
    chk("no_trig_b", int'(write_enable), 0);

    send(16'hF000);
    chk("neg_no_write", int'(write_enable), 0);
    base = wr_count;
    send(16'h0123);
    chk("trig_we", int'(write_enable), 1);
    chk("trig_addr", int'(write_address), 'h100);
    chk("trig_data", int'(write_sample), 'h81);

    // 255 back-to-back strobes with ramp data.
    for (int i = 1; i < 256; i++) begin
      stim.new_sample_ready = 1'b1;
      stim.new_sample_in    = 16'(i * 256 - 32768);
      tick();
      if (i == 255) begin
        chk("last_addr", int'(write_address), 'h1FF);
        chk("last_data", int'(write_sample), 'hFF);
      end
    end
    stim.new_sample_ready = 1'b0;
    tick();
    chk("capture_len", wr_count - base, 256);

    // In WAIT: strobes including crossings produce no writes.
    base = wr_count;
    send(16'h8000);
    send(16'h1000);
    send(16'hFFFF);
    send(16'h0000);
    tick();
    chk("wait_no_write", wr_count - base, 0);

    repeat (100) tick();
    chk("ri_hold", int'(read_index), 0);
    stim.wave_display_idle = 1'b1;
    tick();
    stim.wave_display_idle = 1'b0;
    chk("ri_flip", int'(read_index), 1);

    // Second capture into buffer 0.
    send(16'h8000);
    base = wr_count;
    send(16'h0000);
    chk("cap2_addr0", int'(write_address), 'h000);
    chk("cap2_data0", int'(write_sample), 'h80);
    for (int i = 1; i < 256; i++) begin
      send((i == 255) ? 16'h7FFF : 16'(i * 97));
      if (i == 255) begin
        chk("cap2_last_addr", int'(write_address), 'h0FF);
        chk("cap2_last_data", int'(write_sample), 'hFF);
      end
    end
    tick();
    chk("cap2_len", wr_count - base, 256);

    // Idle and a would-be crossing in the same cycle.
    send(16'hFFFF);
    stim.wave_display_idle = 1'b1;
    stim.new_sample_ready  = 1'b1;
    stim.new_sample_in     = 16'h0000;
    tick();
    stim.wave_display_idle = 1'b0;
    stim.new_sample_ready  = 1'b0;
    chk("idle_cross_ri", int'(read_index), 0);
    chk("idle_cross_we", int'(write_enable), 0);
    tick();
    chk("idle_cross_we2", int'(write_enable), 0);

    // Third capture, interrupted by reset at count 100.
    send(16'hFFFF);
    send(16'h0001);
    chk("cap3_addr0", int'(write_address), 'h100);
    for (int i = 1; i < 100; i++) send(16'(i * 300));
    chk("cap3_addr99", int'(write_address), 'h163);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_we", int'(write_enable), 0);
    chk("mid_rst_addr", int'(write_address), 0);
    chk("mid_rst_data", int'(write_sample), 0);
    chk("mid_rst_ri", int'(read_index), 0);
    @(negedge clk);
    reset = 1'b1;
    base = wr_count;
    send(16'h0100);
    send(16'h0200);
    repeat (5) tick();
    chk("post_rst_no_write", wr_count - base, 0);
    send(16'hC000);
    send(16'h4000);
    chk("post_rst_trig_addr", int'(write_address), 'h100);
    chk("post_rst_trig_data", int'(write_sample), 'hC0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
